// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter.
// Holds the FSM state and transaction owner types plus the fairness counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_grant_logic.sv
// Grant selection between fetch and data requesters, with the fetch-starvation counter.
// Data wins by default; after STARVE_LIMIT data grants with a fetch waiting, fetch is forced.
module arb_grant_logic
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic i_read,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    always_comb begin
        grant_d = enable && d_req && (!i_read || (starve_cnt < LIMIT));
        grant_i = enable && i_read && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_read && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the MEM stage.
// IDLE grants, BUSY waits on M_BUSYWAIT, RESP releases the owner's stall for one cycle.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    state_t state;
    owner_t owner;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    assign d_req = D_READ || D_WRITE;

    arb_grant_logic #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk    (CLK),
        .reset  (RESET),
        .enable (state == IDLE),
        .i_read (I_READ),
        .d_req  (d_req),
        .grant_i(grant_i),
        .grant_d(grant_d)
    );

    // Stalls release only in the owner's RESP cycle; a rising request stalls at once.
    always_comb begin
        I_BUSYWAIT = I_READ && !((state == RESP) && (owner == OWN_I));
        D_BUSYWAIT = d_req  && !((state == RESP) && (owner == OWN_D));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            owner       <= NONE;
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
            I_READDATA  <= '0;
            D_READDATA  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        // Read and write together is treated as a write.
                        owner       <= OWN_D;
                        M_ADDRESS   <= D_ADDRESS;
                        M_WRITEDATA <= D_WRITEDATA;
                        M_WRITE     <= D_WRITE;
                        M_READ      <= !D_WRITE;
                        state       <= BUSY;
                    end else if (grant_i) begin
                        owner     <= OWN_I;
                        M_ADDRESS <= I_ADDRESS;
                        M_WRITE   <= 1'b0;
                        M_READ    <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!M_BUSYWAIT) begin
                        // A withdrawn request still completes, but its data is dropped.
                        case (owner)
                            OWN_I: if (I_READ) I_READDATA <= M_READDATA;
                            OWN_D: if (M_READ && D_READ) D_READDATA <= M_READDATA;
                            default: ;
                        endcase
                        M_READ  <= 1'b0;
                        M_WRITE <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    owner <= NONE;
                    state <= IDLE;
                end
                default: begin
                    owner   <= NONE;
                    M_READ  <= 1'b0;
                    M_WRITE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: memory model with programmable latency,
// transaction scoreboard on the M_* bus, and per-scenario cycle checks.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_READ;
    logic [31:0] I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [31:0] D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 0;
    int          bcnt = 0;
    int          wr_count = 0;
    logic        prev_act = 1'b0;
    logic [31:0] wmem [int];

    always #5 CLK = ~CLK;

    memory_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    function automatic logic [31:0] init_val(int idx);
        return (idx == 4) ? 32'h00A00093 : (32'hA500_0000 | 32'(idx));
    endfunction

    function automatic logic [31:0] mem_val(logic [31:0] addr);
        int idx;
        idx = int'(addr[9:2]);
        return wmem.exists(idx) ? wmem[idx] : init_val(idx);
    endfunction

    // Memory model: busy for 'lat' cycles from the first cycle of each transaction.
    assign M_BUSYWAIT = (M_READ || M_WRITE) && (bcnt < lat);

    always @(posedge CLK) begin
        if (M_READ || M_WRITE) bcnt <= bcnt + 1;
        else bcnt <= 0;
    end

    always @(M_ADDRESS, wr_count) M_READDATA = mem_val(M_ADDRESS);

    initial forever begin
        @(posedge CLK);
        if (M_WRITE && !M_BUSYWAIT) begin
            wmem[int'(M_ADDRESS[9:2])] = M_WRITEDATA;
            wr_count = wr_count + 1;
        end
    end

    // Scoreboard: every new memory transaction must match the next expected one.
    initial forever begin
        @(negedge CLK);
        if ((M_READ || M_WRITE) && !prev_act) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_txn: got read=%b write=%b addr=%h, required no transaction",
                         M_READ, M_WRITE, M_ADDRESS);
            end else begin
                mon_e = sb.pop_front();
                if (M_WRITE !== mon_e.write || M_READ !== !mon_e.write || M_ADDRESS !== mon_e.addr ||
                    (mon_e.write && M_WRITEDATA !== mon_e.wdata)) begin
                    miscompares++;
                    $display("FAIL txn_order: got write=%b read=%b addr=%h wdata=%h, required write=%b addr=%h wdata=%h",
                             M_WRITE, M_READ, M_ADDRESS, M_WRITEDATA, mon_e.write, mon_e.addr, mon_e.wdata);
                end
            end
        end
        prev_act = M_READ || M_WRITE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick();
        tick();
        vectors++;
        if ({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT} !== 4'b0000 || M_ADDRESS !== 32'h0 ||
            M_WRITEDATA !== 32'h0 || I_READDATA !== 32'h0 || D_READDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got rd=%b wr=%b ibw=%b dbw=%b addr=%h wd=%h ird=%h drd=%h, required all 0",
                     M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT, M_ADDRESS, M_WRITEDATA, I_READDATA, D_READDATA);
        end
        I_READ = 1'b1;
        #1;
        vectors++;
        if (I_BUSYWAIT !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busywait: got %b, required 1", I_BUSYWAIT);
        end
        tick();
        vectors++;
        if (M_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_grant: got M_READ=%b, required 0", M_READ);
        end
        I_READ = 1'b0;
        RESET  = 1'b0;
        tick();
    endtask

    task automatic test_fetch;
        lat = 3;
        I_ADDRESS = 32'h10;
        I_READ = 1'b1;
        sb.push_back('{1'b0, 32'h10, 32'h0});
        #1;
        vectors++;
        if (I_BUSYWAIT !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_bw_c0: got %b, required 1", I_BUSYWAIT);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                vectors++;
                if (M_READ !== 1'b1 || M_ADDRESS !== 32'h10) begin
                    miscompares++;
                    $display("FAIL fetch_mread: got rd=%b addr=%h, required rd=1 addr=00000010", M_READ, M_ADDRESS);
                end
            end
            vectors++;
            if (I_BUSYWAIT !== (c != 5)) begin
                miscompares++;
                $display("FAIL fetch_bw_c%0d: got %b, required %b", c, I_BUSYWAIT, (c != 5));
            end
        end
        vectors++;
        if (I_READDATA !== 32'h00A00093) begin
            miscompares++;
            $display("FAIL fetch_data: got %h, required 00a00093", I_READDATA);
        end
        I_READ = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_collision;
        lat = 1;
        D_ADDRESS = 32'h100;
        D_WRITEDATA = 32'hDEADBEEF;
        D_WRITE = 1'b1;
        I_ADDRESS = 32'h20;
        I_READ = 1'b1;
        sb.push_back('{1'b1, 32'h100, 32'hDEADBEEF});
        sb.push_back('{1'b0, 32'h20, 32'h0});
        #1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                vectors++;
                if (M_WRITE !== 1'b1 || M_WRITEDATA !== 32'hDEADBEEF) begin
                    miscompares++;
                    $display("FAIL coll_dwrite: got wr=%b wd=%h, required wr=1 wd=deadbeef", M_WRITE, M_WRITEDATA);
                end
            end
            if (c == 4) begin
                vectors++;
                if (M_READ !== 1'b0 || M_WRITE !== 1'b0) begin
                    miscompares++;
                    $display("FAIL coll_gap: got rd=%b wr=%b, required 0 0", M_READ, M_WRITE);
                end
            end
            if (c == 5) begin
                vectors++;
                if (M_READ !== 1'b1 || M_ADDRESS !== 32'h20) begin
                    miscompares++;
                    $display("FAIL coll_fetch_grant: got rd=%b addr=%h, required rd=1 addr=00000020", M_READ, M_ADDRESS);
                end
            end
            vectors++;
            if (D_BUSYWAIT !== (c < 3) || I_BUSYWAIT !== (c != 7)) begin
                miscompares++;
                $display("FAIL coll_bw_c%0d: got d=%b i=%b, required d=%b i=%b",
                         c, D_BUSYWAIT, I_BUSYWAIT, (c < 3), (c != 7));
            end
            if (c == 3) D_WRITE = 1'b0;
            if (c == 7) begin
                vectors++;
                if (I_READDATA !== init_val(8)) begin
                    miscompares++;
                    $display("FAIL coll_fetch_data: got %h, required %h", I_READDATA, init_val(8));
                end
                I_READ = 1'b0;
            end
        end
        tick();
        vectors++;
        if (mem_val(32'h100) !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL coll_mem: got %h, required deadbeef", mem_val(32'h100));
        end
    endtask

    task automatic test_starvation;
        int  d_resps;
        bit  done;
        d_resps = 0;
        done = 1'b0;
        lat = 0;
        D_ADDRESS = 32'h200;
        D_READ = 1'b1;
        I_ADDRESS = 32'h30;
        I_READ = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 32'h200, 32'h0});
        sb.push_back('{1'b0, 32'h30, 32'h0});
        sb.push_back('{1'b0, 32'h200, 32'h0});
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            if (D_READ && !D_BUSYWAIT) begin
                d_resps++;
                vectors++;
                if (D_READDATA !== init_val(128)) begin
                    miscompares++;
                    $display("FAIL starve_ddata: got %h, required %h", D_READDATA, init_val(128));
                end
                if (!I_READ) begin
                    D_READ = 1'b0;
                    done = 1'b1;
                end
            end
            if (I_READ && !I_BUSYWAIT) begin
                vectors++;
                if (d_resps != 4 || I_READDATA !== init_val(12)) begin
                    miscompares++;
                    $display("FAIL starve_fetch: got d_resps=%0d data=%h, required 4 and %h",
                             d_resps, I_READDATA, init_val(12));
                end
                I_READ = 1'b0;
            end
        end
        vectors++;
        if (!done || d_resps != 5) begin
            miscompares++;
            $display("FAIL starve_resume: got done=%0d d_resps=%0d, required 1 and 5", done, d_resps);
        end
        D_READ = 1'b0;
        I_READ = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        lat = 0;
        D_ADDRESS = 32'h0;
        D_READ = 1'b1;
        sb.push_back('{1'b0, 32'h0, 32'h0});
        sb.push_back('{1'b0, 32'h4, 32'h0});
        #1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            vectors++;
            if (D_BUSYWAIT !== !(c == 2 || c == 5)) begin
                miscompares++;
                $display("FAIL b2b_bw_c%0d: got %b, required %b", c, D_BUSYWAIT, !(c == 2 || c == 5));
            end
            if (c == 3) begin
                vectors++;
                if (M_READ !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_gap: got M_READ=%b, required 0", M_READ);
                end
            end
            if (c == 2) begin
                vectors++;
                if (D_READDATA !== init_val(0)) begin
                    miscompares++;
                    $display("FAIL b2b_data0: got %h, required %h", D_READDATA, init_val(0));
                end
                D_ADDRESS = 32'h4;
            end
            if (c == 5) begin
                vectors++;
                if (D_READDATA !== init_val(1)) begin
                    miscompares++;
                    $display("FAIL b2b_data1: got %h, required %h", D_READDATA, init_val(1));
                end
                D_READ = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_op;
        lat = 5;
        D_ADDRESS = 32'h300;
        D_WRITEDATA = 32'h12345678;
        D_WRITE = 1'b1;
        sb.push_back('{1'b1, 32'h300, 32'h12345678});
        tick();
        vectors++;
        if (M_WRITE !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_start: got M_WRITE=%b, required 1", M_WRITE);
        end
        tick();
        RESET = 1'b1;
        tick();
        vectors++;
        if (M_WRITE !== 1'b0 || M_READ !== 1'b0 || M_ADDRESS !== 32'h0 || M_WRITEDATA !== 32'h0 ||
            I_READDATA !== 32'h0 || D_READDATA !== 32'h0 || D_BUSYWAIT !== 1'b1 || I_BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_state: got wr=%b rd=%b addr=%h wd=%h ird=%h drd=%h dbw=%b ibw=%b, required 0s with dbw=1",
                     M_WRITE, M_READ, M_ADDRESS, M_WRITEDATA, I_READDATA, D_READDATA, D_BUSYWAIT, I_BUSYWAIT);
        end
        RESET = 1'b0;
        D_WRITE = 1'b0;
        #1;
        vectors++;
        if (D_BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_bw: got %b, required 0", D_BUSYWAIT);
        end
        tick();
        tick();
        vectors++;
        if (M_WRITE !== 1'b0 || mem_val(32'h300) !== init_val(192)) begin
            miscompares++;
            $display("FAIL rst_mid_abort: got wr=%b mem=%h, required wr=0 mem=%h",
                     M_WRITE, mem_val(32'h300), init_val(192));
        end
    endtask

    task automatic test_illegal_withdraw;
        lat = 0;
        D_ADDRESS = 32'h104;
        D_WRITEDATA = 32'hCAFEF00D;
        D_READ = 1'b1;
        D_WRITE = 1'b1;
        sb.push_back('{1'b1, 32'h104, 32'hCAFEF00D});
        tick();
        vectors++;
        if (M_WRITE !== 1'b1 || M_READ !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_op: got wr=%b rd=%b, required wr=1 rd=0", M_WRITE, M_READ);
        end
        tick();
        vectors++;
        if (D_BUSYWAIT !== 1'b0 || D_READDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL illegal_resp: got bw=%b rdata=%h, required bw=0 rdata=00000000", D_BUSYWAIT, D_READDATA);
        end
        D_READ = 1'b0;
        D_WRITE = 1'b0;
        tick();
        vectors++;
        if (mem_val(32'h104) !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL illegal_mem: got %h, required cafef00d", mem_val(32'h104));
        end
        lat = 3;
        I_ADDRESS = 32'h10;
        I_READ = 1'b1;
        sb.push_back('{1'b0, 32'h10, 32'h0});
        tick();
        tick();
        I_READ = 1'b0;
        #1;
        vectors++;
        if (I_BUSYWAIT !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_bw: got %b, required 0", I_BUSYWAIT);
        end
        for (int c = 3; c <= 12; c++) begin
            tick();
            vectors++;
            if (M_READ !== (c <= 4) || I_BUSYWAIT !== 1'b0) begin
                miscompares++;
                $display("FAIL withdraw_c%0d: got rd=%b bw=%b, required rd=%b bw=0", c, M_READ, I_BUSYWAIT, (c <= 4));
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        I_READ = 1'b0;
        I_ADDRESS = '0;
        D_READ = 1'b0;
        D_WRITE = 1'b0;
        D_ADDRESS = '0;
        D_WRITEDATA = '0;
        test_reset();
        test_fetch();
        test_collision();
        test_starvation();
        test_back_to_back();
        test_reset_mid_op();
        test_illegal_withdraw();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending transactions, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
